// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared types and constants for the serial frame controller that feeds the
//   1x4 demultiplexer.
//     frame_state_t : parser state (IDLE, ADDR, LEN, DATA)
//     START_BIT     : line value that opens a frame
//     ADDR_W        : width of the channel address field
//     NUM_CH        : number of demux channels (one enable bit each)
// -----------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        LEN  = 2'd2,
        DATA = 2'd3
    } frame_state_t;

    localparam logic START_BIT = 1'b1;
    localparam int   ADDR_W    = 2;
    localparam int   NUM_CH    = 4;

endpackage : demux_pkg

// File: rtl/demux_frame_ctrl_bit_counter.sv
// -----------------------------------------------------------------------------
// frame_bit_counter
//   Loadable down-counter shared by every parse phase of the frame controller.
//   Load has priority over decrement; the count saturates at zero instead of
//   wrapping, so a stray decrement can never turn a finished phase into a
//   2^LEN_W-bit one.
//   Ports:
//     clk      : clock
//     rst_n    : asynchronous active-low reset (count -> 0)
//     load     : load load_val this cycle
//     load_val : value to load
//     dec      : decrement by one (ignored while load is high or count is 0)
//     zero     : count is 0
// -----------------------------------------------------------------------------
module frame_bit_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule : frame_bit_counter

// File: rtl/demux_frame_ctrl.sv
// -----------------------------------------------------------------------------
// demux_frame_ctrl
//   Parses a framed serial bitstream (MSB first: start bit, 2-bit address,
//   LEN_W-bit length N, N payload bits) and drives the 1x4 demux: channel
//   select on S, payload bits on A qualified by out_valid. Frames addressed to
//   a disabled channel are consumed silently and reported with frame_drop.
//   All outputs are registered.
//   Ports:
//     clk        : clock, rising edge active
//     rst_n      : asynchronous active-low reset
//     rx_bit     : serial input bit
//     rx_valid   : rx_bit is accepted on this edge; 0 stalls the parser
//     ch_en      : per-channel enable, sampled with the last address bit
//     A          : payload bit to the demux
//     S          : channel select to the demux
//     out_valid  : A carries a payload bit this cycle
//     busy       : parser is inside a frame
//     frame_done : one-cycle pulse at the end of a delivered frame
//     frame_drop : one-cycle pulse at the end of a dropped frame
// -----------------------------------------------------------------------------
module demux_frame_ctrl
    import demux_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              rx_valid,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              A,
    output logic [ADDR_W-1:0] S,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_drop
);

    frame_state_t state, state_nxt;

    // Only the leading bits of each field are stored; the final bit is taken
    // straight from rx_bit on the edge that completes the field.
    logic [ADDR_W-2:0] addr_sr;
    logic [LEN_W-2:0]  len_sr;
    logic              keep;

    logic [ADDR_W-1:0] addr_cur;
    logic [LEN_W-1:0]  len_cur;

    logic              cnt_load;
    logic [LEN_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;

    logic              payload_acc;
    logic              frame_end;
    logic              addr_last;

    assign addr_cur  = {addr_sr, rx_bit};
    assign len_cur   = {len_sr, rx_bit};
    assign addr_last = rx_valid && (state == ADDR) && cnt_zero;

    frame_bit_counter #(
        .LEN_W (LEN_W)
    ) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // ---- parse stage: state register -------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The counter holds "bits remaining after this one" in every phase, so
    // cnt_zero marks the last bit of the current field.
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        payload_acc  = 1'b0;
        frame_end    = 1'b0;
        if (rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (rx_bit == START_BIT) begin
                        state_nxt    = ADDR;
                        cnt_load     = 1'b1;
                        cnt_load_val = LEN_W'(ADDR_W - 1);
                    end
                end
                ADDR: begin
                    if (cnt_zero) begin
                        state_nxt    = LEN;
                        cnt_load     = 1'b1;
                        cnt_load_val = LEN_W'(LEN_W - 1);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                LEN: begin
                    if (cnt_zero) begin
                        if (len_cur == '0) begin
                            state_nxt = IDLE;
                            frame_end = 1'b1;
                        end else begin
                            state_nxt    = DATA;
                            cnt_load     = 1'b1;
                            cnt_load_val = len_cur - LEN_W'(1);
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                DATA: begin
                    payload_acc = 1'b1;
                    if (cnt_zero) begin
                        state_nxt = IDLE;
                        frame_end = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---- field registers --------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_sr <= '0;
            len_sr  <= '0;
            keep    <= 1'b0;
        end else if (rx_valid) begin
            if (state == ADDR) begin
                addr_sr <= addr_cur[ADDR_W-2:0];
            end
            if (addr_last) begin
                keep <= ch_en[addr_cur];
            end
            if (state == LEN) begin
                len_sr <= len_cur[LEN_W-2:0];
            end
        end
    end

    // ---- output stage -----------------------------------------------------
    // S only moves for frames that will be delivered, so a dropped frame
    // leaves the demux pointed at the last live channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A          <= 1'b0;
            S          <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            if (addr_last && ch_en[addr_cur]) begin
                S <= addr_cur;
            end
            if (payload_acc && keep) begin
                A <= rx_bit;
            end
            out_valid  <= payload_acc && keep;
            busy       <= (state_nxt != IDLE);
            frame_done <= frame_end && keep;
            frame_drop <= frame_end && !keep;
        end
    end

endmodule : demux_frame_ctrl

// File: tb/tb_demux_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_frame_ctrl
//   Self-checking bench for demux_frame_ctrl: a per-cycle vector table for the
//   basic delivered / empty / dropped frames, then scoreboarded sequences for
//   stalls, back-to-back frames, reset mid-payload, maximum length and random
//   traffic.
// -----------------------------------------------------------------------------
module tb_demux_frame_ctrl;

    localparam int LEN_W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_bit = 1'b0;
    logic       rx_valid = 1'b0;
    logic [3:0] ch_en = 4'h0;
    logic       A;
    logic [1:0] S;
    logic       out_valid;
    logic       busy;
    logic       frame_done;
    logic       frame_drop;

    demux_frame_ctrl #(
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .ch_en      (ch_en),
        .A          (A),
        .S          (S),
        .out_valid  (out_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_drop (frame_drop)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit sb_on = 1'b0;
    logic [1:0] exp_s = 2'b00;

    typedef struct {
        logic       a;
        logic [1:0] s;
    } pay_t;

    typedef struct {
        logic done;
        logic drop;
        logic ov;
    } ev_t;

    typedef struct {
        logic       b;
        logic       v;
        logic [3:0] ch;
        logic       a;
        logic [1:0] s;
        logic       ov;
        logic       bz;
        logic       dn;
        logic       dp;
    } vec_t;

    pay_t pay_q[$];
    ev_t  ev_q[$];
    vec_t tbl[31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic b, input logic v, input logic [3:0] ch,
                                input logic a, input logic [1:0] s, input logic ov,
                                input logic bz, input logic dn, input logic dp);
        vec_t r;
        r.b = b; r.v = v; r.ch = ch; r.a = a; r.s = s;
        r.ov = ov; r.bz = bz; r.dn = dn; r.dp = dp;
        return r;
    endfunction

    task automatic drive(input logic b, input logic v);
        @(negedge clk);
        rx_bit   = b;
        rx_valid = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " A"}, 32'(A), 32'(0));
        chk({tag, " S"}, 32'(S), 32'(0));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, " busy"}, 32'(busy), 32'(0));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(0));
        chk({tag, " frame_drop"}, 32'(frame_drop), 32'(0));
    endtask

    // Sends one frame and records what the DUT owes for it. A stall of
    // stall_n cycles is inserted before payload bit stall_at.
    task automatic send_frame(input logic [1:0] addr, input int len, input logic [14:0] pay,
                              input logic [3:0] ch, input int stall_at, input int stall_n);
        logic keep;
        pay_t p;
        ev_t  e;
        keep  = ch[addr];
        ch_en = ch;
        if (keep) exp_s = addr;
        drive(1'b1, 1'b1);
        drive(addr[1], 1'b1);
        drive(addr[0], 1'b1);
        for (int i = LEN_W - 1; i >= 0; i--) begin
            drive(len[i], 1'b1);
            if (i == 0 && len == 0) begin
                e.done = keep; e.drop = !keep; e.ov = 1'b0;
                ev_q.push_back(e);
            end
        end
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < stall_n; k++) begin
                    drive(1'($urandom_range(0, 1)), 1'b0);
                    @(posedge clk);
                    #1;
                    chk("stall out_valid", 32'(out_valid), 32'(0));
                    chk("stall S", 32'(S), 32'(exp_s));
                end
            end
            drive(pay[len-1-i], 1'b1);
            if (keep) begin
                p.a = pay[len-1-i];
                p.s = exp_s;
                pay_q.push_back(p);
            end
            if (i == len - 1) begin
                e.done = keep; e.drop = !keep; e.ov = keep;
                ev_q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor: samples outputs on the falling edge.
    logic prev_end = 1'b0;
    always @(negedge clk) begin
        pay_t p;
        ev_t  e;
        if (sb_on && rst_n) begin
            if (out_valid) begin
                if (pay_q.size() == 0) begin
                    chk("unexpected out_valid", 32'(1), 32'(0));
                end else begin
                    p = pay_q.pop_front();
                    chk("payload A", 32'(A), 32'(p.a));
                    chk("payload S", 32'(S), 32'(p.s));
                end
            end
            if (frame_done || frame_drop) begin
                chk("done/drop exclusive", 32'(frame_done & frame_drop), 32'(0));
                chk("busy in end cycle", 32'(busy), 32'(0));
                chk("end pulse width", 32'(prev_end), 32'(0));
                if (ev_q.size() == 0) begin
                    chk("unexpected end pulse", 32'(1), 32'(0));
                end else begin
                    e = ev_q.pop_front();
                    chk("frame_done", 32'(frame_done), 32'(e.done));
                    chk("frame_drop", 32'(frame_drop), 32'(e.drop));
                    chk("out_valid at end", 32'(out_valid), 32'(e.ov));
                end
            end
        end
        prev_end <= frame_done | frame_drop;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Delivered frame 1,10,0011,101 -> empty frame 1,01,0000 (after idle
        // zeros) -> dropped frame to channel 2 with N=3, back-to-back.
        tbl[0]  = mk(1, 1, 4'hF, 0, 2'b00, 0, 1, 0, 0);
        tbl[1]  = mk(1, 1, 4'hF, 0, 2'b00, 0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 4'hF, 0, 2'b10, 0, 1, 0, 0);
        tbl[3]  = mk(0, 1, 4'hF, 0, 2'b10, 0, 1, 0, 0);
        tbl[4]  = mk(0, 1, 4'hF, 0, 2'b10, 0, 1, 0, 0);
        tbl[5]  = mk(1, 1, 4'hF, 0, 2'b10, 0, 1, 0, 0);
        tbl[6]  = mk(1, 1, 4'hF, 0, 2'b10, 0, 1, 0, 0);
        tbl[7]  = mk(1, 1, 4'hF, 1, 2'b10, 1, 1, 0, 0);
        tbl[8]  = mk(0, 1, 4'hF, 0, 2'b10, 1, 1, 0, 0);
        tbl[9]  = mk(1, 1, 4'hF, 1, 2'b10, 1, 0, 1, 0);
        tbl[10] = mk(0, 0, 4'hF, 1, 2'b10, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 4'hF, 1, 2'b10, 0, 0, 0, 0);
        tbl[12] = mk(0, 1, 4'hF, 1, 2'b10, 0, 0, 0, 0);
        tbl[13] = mk(1, 1, 4'hF, 1, 2'b10, 0, 1, 0, 0);
        tbl[14] = mk(0, 1, 4'hF, 1, 2'b10, 0, 1, 0, 0);
        tbl[15] = mk(1, 1, 4'hF, 1, 2'b01, 0, 1, 0, 0);
        tbl[16] = mk(0, 1, 4'hF, 1, 2'b01, 0, 1, 0, 0);
        tbl[17] = mk(0, 1, 4'hF, 1, 2'b01, 0, 1, 0, 0);
        tbl[18] = mk(0, 1, 4'hF, 1, 2'b01, 0, 1, 0, 0);
        tbl[19] = mk(0, 1, 4'hF, 1, 2'b01, 0, 0, 1, 0);
        tbl[20] = mk(1, 1, 4'hB, 1, 2'b01, 0, 1, 0, 0);
        tbl[21] = mk(1, 1, 4'hB, 1, 2'b01, 0, 1, 0, 0);
        tbl[22] = mk(0, 1, 4'hB, 1, 2'b01, 0, 1, 0, 0);
        tbl[23] = mk(0, 1, 4'hB, 1, 2'b01, 0, 1, 0, 0);
        tbl[24] = mk(0, 1, 4'hB, 1, 2'b01, 0, 1, 0, 0);
        tbl[25] = mk(1, 1, 4'hB, 1, 2'b01, 0, 1, 0, 0);
        tbl[26] = mk(1, 1, 4'hB, 1, 2'b01, 0, 1, 0, 0);
        tbl[27] = mk(1, 1, 4'hB, 1, 2'b01, 0, 1, 0, 0);
        tbl[28] = mk(0, 1, 4'hB, 1, 2'b01, 0, 1, 0, 0);
        tbl[29] = mk(1, 1, 4'hB, 1, 2'b01, 0, 0, 0, 1);
        tbl[30] = mk(0, 1, 4'hB, 1, 2'b01, 0, 0, 0, 0);

        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            rx_bit   = tbl[i].b;
            rx_valid = tbl[i].v;
            ch_en    = tbl[i].ch;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d A", i), 32'(A), 32'(tbl[i].a));
            chk($sformatf("vec%0d S", i), 32'(S), 32'(tbl[i].s));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].bz));
            chk($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(tbl[i].dn));
            chk($sformatf("vec%0d frame_drop", i), 32'(frame_drop), 32'(tbl[i].dp));
        end

        // Stall mid-payload, then an immediate frame to channel 0.
        exp_s = 2'b01;
        sb_on = 1'b1;
        send_frame(2'b11, 2, 15'b11, 4'hF, 1, 2);
        send_frame(2'b00, 3, 15'b010, 4'hF, -1, 0);
        repeat (3) drive(1'b0, 1'b1);

        // Reset asserted asynchronously in the middle of a payload.
        sb_on = 1'b0;
        ch_en = 4'hF;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("pre-reset out_valid", 32'(out_valid), 32'(1));
        chk("pre-reset A", 32'(A), 32'(1));
        chk("pre-reset S", 32'(S), 32'(2'b10));
        chk("pre-reset busy", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_idle_outputs($sformatf("post-reset%0d", k));
        end
        exp_s = 2'b00;
        sb_on = 1'b1;
        send_frame(2'b10, 4, 15'b1011, 4'hF, -1, 0);

        // Maximum length frame; trailing idle zeros would be swallowed as
        // payload if the counter wrapped.
        send_frame(2'b01, 15, 15'h5A3C, 4'hF, -1, 0);
        repeat (4) drive(1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("max-len busy after", 32'(busy), 32'(0));

        // Random traffic with random enables, stalls and idle gaps.
        for (int f = 0; f < 16; f++) begin
            int len;
            int gap;
            len = $urandom_range(0, 15);
            send_frame(2'($urandom_range(0, 3)), len, 15'($urandom), 4'($urandom),
                       $urandom_range(0, 15), $urandom_range(1, 3));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive(1'b0, 1'($urandom_range(0, 1)));
        end
        repeat (4) drive(1'b0, 1'b1);
        @(negedge clk);
        chk("payload queue drained", 32'(pay_q.size()), 32'(0));
        chk("event queue drained", 32'(ev_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_demux_frame_ctrl
